// File: rtl/hazard_ctrl_if.sv
// Bundle between the 5-stage pipeline and hazard_ctrl: stage register/control
// taps toward the unit, enables/flushes/forward selects back to the pipeline.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_req;
  logic              dmem_ready;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              branch_taken;

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              id_byp_a;
  logic              id_byp_b;
  logic              pc_write;
  logic              ifid_write;
  logic              idex_bubble;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;
  logic              stall_all;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Pipeline side: supplies stage state, consumes control.
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite,
           mem_req, dmem_ready, wb_rd, wb_regwrite, branch_taken,
    input  fwd_a, fwd_b, id_byp_a, id_byp_b, pc_write, ifid_write,
           idex_bubble, flush_ifid, flush_idex, flush_exmem,
           stall_all, mem_err, stall_cnt, flush_cnt
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite,
           mem_req, dmem_ready, wb_rd, wb_regwrite, branch_taken,
    output fwd_a, fwd_b, id_byp_a, id_byp_b, pc_write, ifid_write,
           idex_bubble, flush_ifid, flush_idex, flush_exmem,
           stall_all, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX forwarding selects, WB->ID bypass, load-use stall,
// branch flush and data-memory freeze with watchdog. HAZARD_PERF_EN adds perf counters.
module hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam int TW  = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TW1 = TW + 1;
  localparam logic [TW:0] TO_V  = TW1'(TIMEOUT);
  localparam bit          WD_EN = (TIMEOUT > 32'sd0);

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } memState_e;

  // Younger producer (currently in EX) takes priority over the one in MEM.
  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs,
    input logic              used,
    input logic [REG_AW-1:0] exRd,
    input logic              exWr,
    input logic [REG_AW-1:0] memRd,
    input logic              memWr
  );
    logic [1:0] sel;
    if (used && exWr && (exRd != {REG_AW{1'b0}}) && (exRd == rs)) begin
      sel = 2'b10;
    end else if (memWr && (memRd != {REG_AW{1'b0}}) && (memRd == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  memState_e   memState_r;
  memState_e   memStateNext_s;
  logic [TW-1:0] waitCnt_r;
  logic [TW-1:0] waitCntNext_s;
  logic [TW:0]   curWait_s;
  logic        waiting_s;
  logic        timeoutHit_s;
  logic        errState_s;
  logic        fz_s;
  logic        lu_s;
  logic        luA_s;
  logic        luB_s;
  logic [1:0]  fwdA_r;
  logic [1:0]  fwdB_r;
  logic [1:0]  fwdANext_s;
  logic [1:0]  fwdBNext_s;
  logic        pcWrite_s;
  logic        ifidWrite_s;
  logic        idexBubble_s;
  logic        flushAll_s;
  logic        stallAll_s;
  logic        memErr_s;
  logic        bypA_s;
  logic        bypB_s;

  assign waiting_s  = bus.mem_req & ~bus.dmem_ready;
  assign errState_s = (memState_r == MEM_ERR);
  assign fz_s       = waiting_s | errState_s;

  assign luA_s = bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd);
  assign luB_s = bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd);
  assign lu_s  = bus.id_valid & bus.ex_memread & bus.ex_regwrite &
                 (bus.ex_rd != {REG_AW{1'b0}}) & (luA_s | luB_s);

  assign fwdANext_s = fwdSel(bus.id_rs1, bus.id_rs1_used, bus.ex_rd, bus.ex_regwrite,
                             bus.mem_rd, bus.mem_regwrite);
  assign fwdBNext_s = fwdSel(bus.id_rs2, bus.id_rs2_used, bus.ex_rd, bus.ex_regwrite,
                             bus.mem_rd, bus.mem_regwrite);

  // Number of the wait cycle in progress, counting the one being evaluated now.
  always_comb begin
    curWait_s = {TW1{1'b0}};
    if (memState_r == MEM_WAIT) begin
      curWait_s = {1'b0, waitCnt_r} + {{TW{1'b0}}, 1'b1};
    end else begin
      curWait_s = {{TW{1'b0}}, 1'b1};
    end
    timeoutHit_s = WD_EN && waiting_s && (memState_r != MEM_ERR) && (curWait_s >= TO_V);
  end

  // Memory FSM next-state and wait counter.
  always_comb begin
    memStateNext_s = memState_r;
    waitCntNext_s  = waitCnt_r;
    case (memState_r)
      MEM_IDLE: begin
        if (timeoutHit_s) begin
          memStateNext_s = MEM_ERR;
        end else if (waiting_s) begin
          memStateNext_s = MEM_WAIT;
          waitCntNext_s  = curWait_s[TW-1:0];
        end else begin
          waitCntNext_s  = {TW{1'b0}};
        end
      end
      MEM_WAIT: begin
        if (!waiting_s) begin
          memStateNext_s = MEM_IDLE;
          waitCntNext_s  = {TW{1'b0}};
        end else if (timeoutHit_s) begin
          memStateNext_s = MEM_ERR;
        end else if (WD_EN) begin
          waitCntNext_s  = curWait_s[TW-1:0];
        end else begin
          waitCntNext_s  = waitCnt_r;
        end
      end
      MEM_ERR: begin
        memStateNext_s = MEM_ERR;
      end
      default: begin
        memStateNext_s = MEM_IDLE;
        waitCntNext_s  = {TW{1'b0}};
      end
    endcase
  end

  // Memory FSM state and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memState_r <= MEM_IDLE;
      waitCnt_r  <= {TW{1'b0}};
    end else begin
      memState_r <= memStateNext_s;
      waitCnt_r  <= waitCntNext_s;
    end
  end

  // Pipeline control priority: freeze, then branch flush, then load-use.
  // Reset forces the run values immediately, even against a live freeze.
  always_comb begin
    pcWrite_s    = 1'b1;
    ifidWrite_s  = 1'b1;
    idexBubble_s = 1'b0;
    flushAll_s   = 1'b0;
    stallAll_s   = 1'b0;
    if (!reset) begin
      pcWrite_s    = 1'b1;
      ifidWrite_s  = 1'b1;
    end else if (fz_s) begin
      stallAll_s   = 1'b1;
      pcWrite_s    = 1'b0;
      ifidWrite_s  = 1'b0;
    end else if (bus.branch_taken) begin
      flushAll_s   = 1'b1;
    end else if (lu_s) begin
      pcWrite_s    = 1'b0;
      ifidWrite_s  = 1'b0;
      idexBubble_s = 1'b1;
    end else begin
      pcWrite_s    = 1'b1;
      ifidWrite_s  = 1'b1;
    end
  end

  // Same-cycle WB->ID bypass and error flag.
  always_comb begin
    bypA_s   = reset & bus.id_rs1_used & bus.wb_regwrite &
               (bus.wb_rd != {REG_AW{1'b0}}) & (bus.wb_rd == bus.id_rs1);
    bypB_s   = reset & bus.id_rs2_used & bus.wb_regwrite &
               (bus.wb_rd != {REG_AW{1'b0}}) & (bus.wb_rd == bus.id_rs2);
    memErr_s = reset & (errState_s | timeoutHit_s);
  end

  // Forwarding selects follow the consumer from ID into EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwdA_r <= 2'b00;
      fwdB_r <= 2'b00;
    end else if (fz_s) begin
      fwdA_r <= fwdA_r;
      fwdB_r <= fwdB_r;
    end else if (bus.branch_taken || lu_s) begin
      fwdA_r <= 2'b00;
      fwdB_r <= 2'b00;
    end else begin
      fwdA_r <= fwdANext_s;
      fwdB_r <= fwdBNext_s;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stallCnt_r;
  logic [CNT_W-1:0] flushCnt_r;

  // Saturating stall/flush event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_r <= {CNT_W{1'b0}};
      flushCnt_r <= {CNT_W{1'b0}};
    end else begin
      if ((stallAll_s || idexBubble_s) && !(&stallCnt_r)) begin
        stallCnt_r <= stallCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stallCnt_r <= stallCnt_r;
      end
      if (flushAll_s && !(&flushCnt_r)) begin
        flushCnt_r <= flushCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flushCnt_r <= flushCnt_r;
      end
    end
  end

  assign bus.stall_cnt = stallCnt_r;
  assign bus.flush_cnt = flushCnt_r;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

  assign bus.fwd_a       = fwdA_r;
  assign bus.fwd_b       = fwdB_r;
  assign bus.id_byp_a    = bypA_s;
  assign bus.id_byp_b    = bypB_s;
  assign bus.pc_write    = pcWrite_s;
  assign bus.ifid_write  = ifidWrite_s;
  assign bus.idex_bubble = idexBubble_s;
  assign bus.flush_ifid  = flushAll_s;
  assign bus.flush_idex  = flushAll_s;
  assign bus.flush_exmem = flushAll_s;
  assign bus.stall_all   = stallAll_s;
  assign bus.mem_err     = memErr_s;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT=4); expected values worked out by hand.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk;
  logic rstN;
  int   nRun;
  int   nFail;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) hif ();

  hazard_ctrl #(.REG_AW(5), .TIMEOUT(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (rstN),
    .bus   (hif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nRun++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIns();
    hif.id_valid     = 1'b0;
    hif.id_rs1       = 5'd0;
    hif.id_rs2       = 5'd0;
    hif.id_rs1_used  = 1'b0;
    hif.id_rs2_used  = 1'b0;
    hif.ex_rd        = 5'd0;
    hif.ex_regwrite  = 1'b0;
    hif.ex_memread   = 1'b0;
    hif.mem_rd       = 5'd0;
    hif.mem_regwrite = 1'b0;
    hif.mem_req      = 1'b0;
    hif.dmem_ready   = 1'b0;
    hif.wb_rd        = 5'd0;
    hif.wb_regwrite  = 1'b0;
    hif.branch_taken = 1'b0;
  endtask

  task automatic setConsumer(input logic [4:0] rs1, input logic [4:0] rs2);
    hif.id_valid    = 1'b1;
    hif.id_rs1      = rs1;
    hif.id_rs1_used = 1'b1;
    hif.id_rs2      = rs2;
    hif.id_rs2_used = 1'b1;
  endtask

  task automatic checkResetVals(input string tag);
    checkVal({tag, "_fwdA"}, 32'(hif.fwd_a), 32'd0);
    checkVal({tag, "_fwdB"}, 32'(hif.fwd_b), 32'd0);
    checkVal({tag, "_pc"},   32'(hif.pc_write), 32'd1);
    checkVal({tag, "_ifid"}, 32'(hif.ifid_write), 32'd1);
    checkVal({tag, "_bub"},  32'(hif.idex_bubble), 32'd0);
    checkVal({tag, "_stall"}, 32'(hif.stall_all), 32'd0);
    checkVal({tag, "_flush"}, 32'(hif.flush_ifid), 32'd0);
    checkVal({tag, "_err"},  32'(hif.mem_err), 32'd0);
    checkVal({tag, "_scnt"}, 32'(hif.stall_cnt), 32'd0);
    checkVal({tag, "_fcnt"}, 32'(hif.flush_cnt), 32'd0);
  endtask

  initial begin
    nRun  = 0;
    nFail = 0;
    rstN  = 1'b0;
    clearIns();
    #12;
    checkResetVals("rst");
    rstN = 1'b1;
    tick();

    // ALU producer in EX, consumer in ID: EX/MEM forward, no stall
    setConsumer(5'd1, 5'd3);
    hif.ex_rd = 5'd1; hif.ex_regwrite = 1'b1;
    #2;
    checkVal("fwdEx_pc", 32'(hif.pc_write), 32'd1);
    checkVal("fwdEx_bub", 32'(hif.idex_bubble), 32'd0);
    tick();
    checkVal("fwdEx_a", 32'(hif.fwd_a), 32'd2);
    checkVal("fwdEx_b", 32'(hif.fwd_b), 32'd0);

    // lw x5 ; add x6,x5,x7: one bubble, then WB forward
    clearIns();
    setConsumer(5'd5, 5'd7);
    hif.ex_rd = 5'd5; hif.ex_regwrite = 1'b1; hif.ex_memread = 1'b1;
    #2;
    checkVal("lu_pc", 32'(hif.pc_write), 32'd0);
    checkVal("lu_ifid", 32'(hif.ifid_write), 32'd0);
    checkVal("lu_bub", 32'(hif.idex_bubble), 32'd1);
    checkVal("lu_stall", 32'(hif.stall_all), 32'd0);
    tick();
    checkVal("lu_fwdA0", 32'(hif.fwd_a), 32'd0);
    hif.ex_rd = 5'd0; hif.ex_regwrite = 1'b0; hif.ex_memread = 1'b0;
    hif.mem_rd = 5'd5; hif.mem_regwrite = 1'b1;
    #2;
    checkVal("lu2_pc", 32'(hif.pc_write), 32'd1);
    checkVal("lu2_bub", 32'(hif.idex_bubble), 32'd0);
    tick();
    checkVal("lu_fwdA1", 32'(hif.fwd_a), 32'd1);
    checkVal("lu_fwdB", 32'(hif.fwd_b), 32'd0);
    checkVal("lu_scnt", 32'(hif.stall_cnt), 32'(PERF));

    // taken branch wins over a simultaneous load-use
    clearIns();
    setConsumer(5'd5, 5'd7);
    hif.ex_rd = 5'd5; hif.ex_regwrite = 1'b1; hif.ex_memread = 1'b1;
    hif.branch_taken = 1'b1;
    #2;
    checkVal("br_fifid", 32'(hif.flush_ifid), 32'd1);
    checkVal("br_fidex", 32'(hif.flush_idex), 32'd1);
    checkVal("br_fexmem", 32'(hif.flush_exmem), 32'd1);
    checkVal("br_bub", 32'(hif.idex_bubble), 32'd0);
    checkVal("br_pc", 32'(hif.pc_write), 32'd1);
    tick();
    checkVal("br_fwdA", 32'(hif.fwd_a), 32'd0);
    checkVal("br_fcnt", 32'(hif.flush_cnt), 32'(PERF));
    checkVal("br_scnt", 32'(hif.stall_cnt), 32'(PERF));
    clearIns();
    #2;
    checkVal("br_fifid_off", 32'(hif.flush_ifid), 32'd0);
    tick();

    // x0 never forwards; WB bypass to rs2 in the same cycle
    setConsumer(5'd1, 5'd0);
    hif.ex_rd = 5'd1; hif.ex_regwrite = 1'b1;
    tick();
    checkVal("x0_pre", 32'(hif.fwd_a), 32'd2);
    clearIns();
    setConsumer(5'd0, 5'd9);
    hif.ex_rd = 5'd0; hif.ex_regwrite = 1'b1;
    hif.wb_rd = 5'd9; hif.wb_regwrite = 1'b1;
    hif.mem_rd = 5'd9; hif.mem_regwrite = 1'b1;
    #2;
    checkVal("byp_b", 32'(hif.id_byp_b), 32'd1);
    checkVal("byp_a", 32'(hif.id_byp_a), 32'd0);
    tick();
    checkVal("x0_fwdA", 32'(hif.fwd_a), 32'd0);
    checkVal("x0_fwdB", 32'(hif.fwd_b), 32'd1);

    // 3-cycle memory freeze holds the forwarding selects
    clearIns();
    setConsumer(5'd1, 5'd3);
    hif.ex_rd = 5'd1; hif.ex_regwrite = 1'b1;
    hif.mem_rd = 5'd3; hif.mem_regwrite = 1'b1;
    tick();
    checkVal("fz_preA", 32'(hif.fwd_a), 32'd2);
    checkVal("fz_preB", 32'(hif.fwd_b), 32'd1);
    clearIns();
    setConsumer(5'd2, 5'd4);
    hif.mem_req = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkVal("fz_stall", 32'(hif.stall_all), 32'd1);
      checkVal("fz_pc", 32'(hif.pc_write), 32'd0);
      checkVal("fz_err", 32'(hif.mem_err), 32'd0);
      tick();
      checkVal("fz_holdA", 32'(hif.fwd_a), 32'd2);
      checkVal("fz_holdB", 32'(hif.fwd_b), 32'd1);
    end
    hif.dmem_ready = 1'b1;
    #2;
    checkVal("fz_rel_stall", 32'(hif.stall_all), 32'd0);
    checkVal("fz_rel_pc", 32'(hif.pc_write), 32'd1);
    tick();
    checkVal("fz_scnt", 32'(hif.stall_cnt), 32'(4 * PERF));

    // watchdog: error on the 4th wait cycle, sticky afterwards
    clearIns();
    setConsumer(5'd1, 5'd0);
    hif.ex_rd = 5'd1; hif.ex_regwrite = 1'b1;
    tick();
    clearIns();
    hif.mem_req = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #2;
      checkVal("to_err", 32'(hif.mem_err), (i >= 4) ? 32'd1 : 32'd0);
      checkVal("to_stall", 32'(hif.stall_all), 32'd1);
      tick();
    end
    checkVal("to_holdA", 32'(hif.fwd_a), 32'd2);
    hif.mem_req = 1'b0;
    #2;
    checkVal("err_sticky", 32'(hif.mem_err), 32'd1);
    checkVal("err_stall", 32'(hif.stall_all), 32'd1);

    // asynchronous reset out of ERR
    #1 rstN = 1'b0;
    #1;
    checkResetVals("rstErr");
    #2 rstN = 1'b1;
    tick();
    #2;
    checkVal("postErr_pc", 32'(hif.pc_write), 32'd1);
    checkVal("postErr_stall", 32'(hif.stall_all), 32'd0);
    checkVal("postErr_err", 32'(hif.mem_err), 32'd0);

    // asynchronous reset in the middle of a freeze
    tick();
    hif.mem_req = 1'b1; hif.dmem_ready = 1'b0;
    #2;
    checkVal("midStall_on", 32'(hif.stall_all), 32'd1);
    rstN = 1'b0;
    #1;
    checkVal("midStall_rst_stall", 32'(hif.stall_all), 32'd0);
    checkVal("midStall_rst_pc", 32'(hif.pc_write), 32'd1);
    checkVal("midStall_rst_ifid", 32'(hif.ifid_write), 32'd1);
    clearIns();
    rstN = 1'b1;
    tick();
    #2;
    checkVal("midStall_run_pc", 32'(hif.pc_write), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
